// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and helpers for the arb_mux channel arbiter.
//   MODE_FIXED / MODE_RR : arbitration policy selectors
//   ch_w()               : width of a channel index, never less than one bit
package arb_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // A single channel still needs a one-bit index port.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational request arbiter.
//   req       : per-channel requests
//   ptr       : round-robin search start (ignored in fixed-priority mode)
//   grant     : one-hot grant among asserted requests, zero if none
//   grant_idx : index of the granted channel (0 when nothing is granted)
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MODE   = MODE_RR,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  always_comb begin : p_arb
    logic found;
    int   start;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // Fixed priority is a round-robin search that always starts at 0.
    start = (MODE == MODE_RR) ? int'(ptr) : 0;
    if (start >= NUM_CH) start = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = start + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel arbitrated multiplexer with a one-word registered output.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-channel request
//   in_data    : packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_ready   : one-hot consume strobe for the granted channel
//   out_valid  : output register holds a word
//   out_data   : registered selected word
//   out_ch     : channel that supplied out_data
//   out_ready  : downstream accept
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4,
  parameter int MODE   = MODE_RR,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_grant_idx;
  logic              w_load;
  logic [WIDTH-1:0]  w_sel_data;
  logic [CH_W-1:0]   w_ptr_nxt;

  logic [CH_W-1:0]   r_ptr;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [CH_W-1:0]   r_out_ch;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Load when the output slot is empty or being drained this cycle; rst
  // blocks the load so nothing is consumed during a reset cycle.
  assign w_load   = !rst && (!r_out_valid || out_ready) && (|in_valid);
  assign in_ready = w_load ? w_grant : '0;

  // AND-OR select keyed by the one-hot grant.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_nxt = (int'(w_grant_idx) == NUM_CH - 1) ? '0 : CH_W'(w_grant_idx + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load && (MODE == MODE_RR)) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Output register: load wins over drain so back-to-back words flow with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic [3:0]  rdy_rr, rdy_fx;
  logic        ov_rr, ov_fx;
  logic [15:0] od_rr, od_fx;
  logic [1:0]  oc_rr, oc_fx;

  arb_mux #(.WIDTH(16), .NUM_CH(4), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_ch(oc_rr),
    .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(16), .NUM_CH(4), .MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fx), .out_valid(ov_fx), .out_data(od_fx), .out_ch(oc_fx),
    .out_ready(out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per policy: index 0 = fixed priority, 1 = round robin.
  int m_valid [2];
  int m_data  [2];
  int m_ch    [2];
  int m_ptr   [2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(int mode, int ptr, logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (mode == 1) ? (ptr + k) % 4 : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit model_load(int mode);
    if (rst) return 1'b0;
    if (m_valid[mode] != 0 && !out_ready) return 1'b0;
    return in_valid != 4'b0000;
  endfunction

  function automatic int exp_ready(int mode);
    if (!model_load(mode)) return 0;
    return 1 << pick(mode, m_ptr[mode], in_valid);
  endfunction

  task automatic model_edge();
    bit ld [2];
    int g  [2];
    for (int m = 0; m < 2; m++) begin
      ld[m] = model_load(m);
      g[m]  = pick(m, m_ptr[m], in_valid);
    end
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 0; m_data[m] = 0; m_ch[m] = 0; m_ptr[m] = 0;
      end else if (ld[m]) begin
        m_valid[m] = 1;
        m_data[m]  = int'(in_data[g[m]*16 +: 16]);
        m_ch[m]    = g[m];
        if (m == 1) m_ptr[m] = (g[m] + 1) % 4;
      end else if (out_ready) begin
        m_valid[m] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("rr_in_ready",  32'(rdy_rr),         32'(exp_ready(1)));
    check("rr_out_valid", 32'(ov_rr),          32'(m_valid[1]));
    check("rr_out_data",  32'(od_rr),          32'(m_data[1]));
    check("rr_out_ch",    32'(oc_rr),          32'(m_ch[1]));
    check("rr_ptr",       32'(dut_rr.r_ptr),   32'(m_ptr[1]));
    check("fx_in_ready",  32'(rdy_fx),         32'(exp_ready(0)));
    check("fx_out_valid", 32'(ov_fx),          32'(m_valid[0]));
    check("fx_out_data",  32'(od_fx),          32'(m_data[0]));
    check("fx_out_ch",    32'(oc_fx),          32'(m_ch[0]));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  localparam logic [63:0] PAT = 64'h4444_3333_2222_1111;
  int exp_seq [5] = '{0, 1, 2, 3, 0};
  int exp_dat [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = 0; m_ch[m] = 0; m_ptr[m] = 0;
    end
    @(posedge clk); #1;
    do_reset();
    check("reset_out_valid", 32'(ov_rr), 32'd0);
    check("reset_out_data",  32'(od_rr), 32'd0);
    check("reset_ptr",       32'(dut_rr.r_ptr), 32'd0);

    // Rotation across all channels vs. fixed priority.
    in_valid = 4'b1111; in_data = PAT; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("fixed_in_ready", 32'(rdy_fx), 32'h1);
      tick();
      check("rr_seq_ch",   32'(oc_rr), 32'(exp_seq[c]));
      check("rr_seq_data", 32'(od_rr), 32'(exp_dat[c]));
      check("fixed_ch",    32'(oc_fx), 32'd0);
      check("fixed_data",  32'(od_fx), 32'h1111);
    end

    // Backpressure holds word, pointer and in_ready.
    do_reset();
    in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", 32'(rdy_rr), 32'd0);
      tick();
      check("bp_out_valid", 32'(ov_rr), 32'd1);
      check("bp_out_data",  32'(od_rr), 32'h1111);
      check("bp_ptr",       32'(dut_rr.r_ptr), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(rdy_rr), 32'b0010);
    tick();
    check("bp_release_ch", 32'(oc_rr), 32'd1);

    // Wrap search from ptr=3 back to channel 1.
    do_reset();
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    check("wrap_ptr3", 32'(dut_rr.r_ptr), 32'd3);
    in_valid = 4'b0010;
    tick();
    check("wrap_ch",  32'(oc_rr), 32'd1);
    check("wrap_ptr", 32'(dut_rr.r_ptr), 32'd2);

    // Idle input drains the output register.
    in_valid = 4'b0000;
    #1;
    check("idle_in_ready", 32'(rdy_rr), 32'd0);
    tick();
    check("idle_out_valid", 32'(ov_rr), 32'd0);

    // Reset while a word is held.
    in_data = 64'h0000_0000_0000_BEEF; in_valid = 4'b0001;
    tick();
    check("beef_loaded", 32'(od_rr), 32'hBEEF);
    out_ready = 1'b0; rst = 1'b1; in_valid = 4'b1111;
    #1;
    check("rst_in_ready", 32'(rdy_rr), 32'd0);
    tick();
    rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    check("rst_out_valid", 32'(ov_rr), 32'd0);
    check("rst_out_data",  32'(od_rr), 32'd0);
    check("rst_ptr",       32'(dut_rr.r_ptr), 32'd0);
    tick();
    check("rst_no_emit", 32'(ov_rr), 32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
- REQ-001: Parameter WIDTH, default 16: data width of every channel and of the output.
- REQ-002: Parameter NUM_CH, default 4: number of input channels, legal range 1..16.
- REQ-003: Parameter MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round robin.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: rst  input  1  reset, synchronous and active-high.
- REQ-006: in_valid  input  NUM_CH  per-channel request; bit i means in_data slice i is valid.
- REQ-007: in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-008: in_ready  output  NUM_CH  one-hot or zero; bit i means channel i is consumed this cycle.
- REQ-009: out_valid  output  1  output register holds a valid word.
- REQ-010: out_data  output  WIDTH  registered selected word.
- REQ-011: out_ch  output  CH_W  index of the channel that supplied out_data; CH_W = max(1, clog2(NUM_CH)).
- REQ-012: out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.

Function
- REQ-013: The block SHALL consume an input word on channel i in the cycle where in_valid[i] and in_ready[i] are both high.
- REQ-014: load = (!out_valid || out_ready) && |in_valid; in_ready SHALL equal grant when load is high, and zero otherwise.
- REQ-015: grant SHALL be combinational and one-hot among the asserted in_valid bits, and SHALL be zero when in_valid is zero.
- REQ-016: MODE 0: grant SHALL select the lowest asserted index.
- REQ-017: MODE 1: grant SHALL select the first asserted index at or after pointer ptr, searching upward and wrapping from NUM_CH-1 to 0.
- REQ-018: On each load in MODE 1, ptr SHALL become granted index + 1, wrapping to 0 after NUM_CH-1; otherwise ptr holds.
- REQ-019: On load, out_data SHALL take the granted slice, out_ch SHALL take the granted index, and out_valid SHALL be 1 at the next edge; latency is one cycle.
- REQ-020: If out_valid && out_ready && !load, out_valid SHALL clear; out_data and out_ch hold their values.
- REQ-021: If out_valid && !out_ready, out_valid, out_data, out_ch and ptr SHALL hold, and in_ready SHALL be zero (backpressure).
- REQ-022: Simultaneous drain and load SHALL sustain one word per cycle with no bubble.
- REQ-023: An asserted in_valid that is not granted SHALL NOT be consumed; the source holds it until granted.
- REQ-024: NUM_CH=1 SHALL behave as a registered pass-through with valid/ready; out_ch is constant 0.

Reset
- REQ-025: While rst is high at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
- REQ-026: in_ready SHALL be zero during any cycle in which rst is high.
- REQ-027: Reset mid-transfer SHALL discard the held word; no word is emitted after reset unless a new load occurs.

Structure
- REQ-028: Package arb_mux_pkg SHALL hold the constants MODE_FIXED=0 and MODE_RR=1 and a clog2-based CH_W helper.
- REQ-029: Grant logic SHALL be one sub-module, rr_arbiter (NUM_CH, MODE; in: req, ptr; out: grant, grant_idx), purely combinational.
- REQ-030: ptr and the output register SHALL live in arb_mux; there is no other storage.

Verification (WIDTH=16, NUM_CH=4)
- REQ-031: MODE 1, in_valid=4'b1111, in_data={0x4444,0x3333,0x2222,0x1111}, out_ready=1 -> out_ch 0,1,2,3,0 on consecutive cycles; out_data 0x1111,0x2222,0x3333,0x4444,0x1111.
- REQ-032: MODE 0, same stimulus -> out_ch=0 and out_data=0x1111 every cycle; in_ready=4'b0001 every cycle.
- REQ-033: MODE 1, one word loaded, then out_ready=0 for 3 cycles -> out_valid=1, out_data stable, in_ready=0, ptr unchanged; out_ready=1 -> a new word is loaded in the same cycle.
- REQ-034: MODE 1, ptr=3, in_valid=4'b0010 -> grant 1, out_ch=1, ptr becomes 2.
- REQ-035: rst pulsed while out_valid=1 and out_data=0xBEEF -> next cycle out_valid=0, out_data=0, ptr=0, in_ready=0 during the reset cycle.
- REQ-036: in_valid=0 with out_ready=1 after one word -> out_valid clears after one cycle and in_ready stays 0.
